// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_types_pkg                                                              |
// | Shared CPU types: instruction-cache frame layout, geometry and FSM states. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_responder_frame_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_frame_array                                                         |
// | Direct-mapped frame store: async read by index, sync single write port.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_frame_array #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];

    // Only the valid bits need reset; stale tag/data is harmless once invalid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_responder                                                           |
// | Direct-mapped one-word-per-frame I-cache; optional ICACHE_STATS_EN counters|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int c_tag_w = 32 - IDX_W - 2;

    icache_state_t      r_state;
    icache_state_t      w_next_state;
    logic [29:0]        r_miss_addr;
    logic               w_rd_valid;
    logic [c_tag_w-1:0] w_rd_tag;
    logic [31:0]        w_rd_data;
    logic               w_hit;
    logic               w_miss_start;
    logic               w_fill;
    logic               w_unused_addr;

    assign w_unused_addr = &{1'b0, imemaddr[1:0]};

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (c_tag_w)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (imemaddr[IDX_W+1:2]),
        .rd_valid (w_rd_valid),
        .rd_tag   (w_rd_tag),
        .rd_data  (w_rd_data),
        .wr_en    (w_fill),
        .wr_idx   (r_miss_addr[IDX_W-1:0]),
        .wr_tag   (r_miss_addr[29:IDX_W]),
        .wr_data  (iload)
    );

    // Lookups only happen in IDLE, so a fill never races a hit compare.
    assign w_hit        = (r_state == IDLE) && imemREN && w_rd_valid
                          && (w_rd_tag == imemaddr[31:IDX_W+2]);
    assign w_miss_start = (r_state == IDLE) && imemREN && !w_hit;
    assign w_fill       = (r_state == MISS) && !iwait;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_miss_start) w_next_state = MISS;
            MISS:    if (!iwait)       w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_miss_addr <= '0;
        end else if (w_miss_start) begin
            r_miss_addr <= imemaddr[31:2];
        end
    end

    assign ihit     = w_hit;
    assign imemload = w_hit ? w_rd_data : 32'd0;
    assign iREN     = (r_state == MISS);
    assign iaddr    = (r_state == MISS) ? {r_miss_addr, 2'b00} : 32'd0;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_start && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_icache_responder                                                        |
// | Directed bench with a word-address cache model checked every cycle.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'd0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b0;
    logic [31:0] iload = 32'd0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    icache_responder #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
`ifdef ICACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .iwait      (iwait),
        .iload      (iload)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Model: each slot remembers which word address it caches.
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    logic [29:0] m_pend;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_busy   = 1'b0;
        m_pend   = '0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    initial model_reset();

    always @(negedge CLK) begin
        int          slot;
        logic        e_hit;
        logic [31:0] e_load;
        if (RST) begin
            chk("rst_ihit", {31'd0, ihit}, 32'd0);
            chk("rst_imemload", imemload, 32'd0);
            chk("rst_iREN", {31'd0, iREN}, 32'd0);
            chk("rst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
            chk("rst_hit_count", hit_count, 32'd0);
            chk("rst_miss_count", miss_count, 32'd0);
`endif
            model_reset();
        end else begin
            slot   = int'(imemaddr[31:2] % 16);
            e_hit  = !m_busy && imemREN && m_valid[slot] && (m_word[slot] == imemaddr[31:2]);
            e_load = e_hit ? m_data[slot] : 32'd0;
            chk("ihit", {31'd0, ihit}, {31'd0, e_hit});
            chk("imemload", imemload, e_load);
            chk("iREN", {31'd0, iREN}, {31'd0, m_busy});
            chk("iaddr", iaddr, m_busy ? {m_pend, 2'b00} : 32'd0);
`ifdef ICACHE_STATS_EN
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_misses);
`endif
            if (m_busy) begin
                if (!iwait) begin
                    m_valid[int'(m_pend % 16)] = 1'b1;
                    m_word[int'(m_pend % 16)]  = m_pend;
                    m_data[int'(m_pend % 16)]  = iload;
                    m_busy = 1'b0;
                end
            end else if (imemREN && !e_hit) begin
                m_busy = 1'b1;
                m_pend = imemaddr[31:2];
                if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 32'd1;
            end else if (e_hit && m_hits != 32'hFFFF_FFFF) begin
                m_hits = m_hits + 32'd1;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic peek();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        step();
        peek();
        chk("lit_rst_iREN", {31'd0, iREN}, 32'd0);
        chk("lit_rst_iaddr", iaddr, 32'd0);
        step();
        RST = 1'b0;

        // First miss and fill of 0x40.
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = 32'hDEAD_BEEF;
        peek();
        chk("lit_first_miss_ihit", {31'd0, ihit}, 32'd0);
        step();
        peek();
        chk("lit_miss_iREN", {31'd0, iREN}, 32'd1);
        chk("lit_miss_iaddr", iaddr, 32'h40);
        step();
        peek();
        chk("lit_fill_ihit", {31'd0, ihit}, 32'd1);
        chk("lit_fill_imemload", imemload, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) step();
        step();
        imemREN = 1'b0;
        peek();
`ifdef ICACHE_STATS_EN
        chk("lit_hit_count6", hit_count, 32'd6);
`endif

        // Conflict on index 0: 0x80 evicts 0x40, then 0x40 misses again.
        step();
        imemREN = 1'b1; imemaddr = 32'h80; iload = 32'h1111_1111;
        peek();
        chk("lit_conflict_miss", {31'd0, ihit}, 32'd0);
        step();
        step();
        peek();
        chk("lit_conflict_data", imemload, 32'h1111_1111);
        step();
        imemaddr = 32'h40; iload = 32'h2222_2222;
        peek();
        chk("lit_evicted_miss", {31'd0, ihit}, 32'd0);
        step();
        step();
        peek();
        chk("lit_refill_data", imemload, 32'h2222_2222);
`ifdef ICACHE_STATS_EN
        chk("lit_miss_count3", miss_count, 32'd3);
`endif

        // Memory stalls for four MISS cycles; fill lands on the fifth.
        step();
        imemaddr = 32'h8; iwait = 1'b1; iload = 32'h3333_3333;
        step();
        for (int i = 0; i < 4; i++) begin
            peek();
            chk("lit_stall_iaddr", iaddr, 32'h8);
            chk("lit_stall_ihit", {31'd0, ihit}, 32'd0);
            step();
        end
        iwait = 1'b0;
        peek();
        chk("lit_stall_iREN", {31'd0, iREN}, 32'd1);
        step();
        peek();
        chk("lit_stall_fill", imemload, 32'h3333_3333);

        // Address moves during MISS: frame 1 still gets 0x44.
        step();
        imemaddr = 32'h44; iload = 32'h4444_4444;
        step();
        imemaddr = 32'h100;
        peek();
        chk("lit_moved_iaddr", iaddr, 32'h44);
        step();
        iload = 32'h5555_5555;
        peek();
        chk("lit_moved_new_miss", {31'd0, ihit}, 32'd0);
        step();
        step();
        imemaddr = 32'h44;
        peek();
        chk("lit_moved_hit", imemload, 32'h4444_4444);

        // Refill 0x40, then reset in the middle of a stalled miss.
        step();
        imemaddr = 32'h40; iload = 32'h6666_6666;
        step();
        step();
        peek();
        chk("lit_refill40", imemload, 32'h6666_6666);
        step();
        imemaddr = 32'h8C; iwait = 1'b1;
        step();
        #2;
        RST = 1'b1;
        #1;
        chk("lit_async_iREN", {31'd0, iREN}, 32'd0);
        chk("lit_async_iaddr", iaddr, 32'd0);
        step();
        RST = 1'b0;
        imemaddr = 32'h40; iwait = 1'b0; iload = 32'h7777_7777;
        peek();
        chk("lit_post_rst_miss", {31'd0, ihit}, 32'd0);
        step();
        peek();
        chk("lit_post_rst_iaddr", iaddr, 32'h40);
        step();
        imemREN = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
